// File: rtl/rv_shift_pkg.sv
// rtl/rv_shift_pkg.sv - shared types and defaults for the shift issue stage
package rv_shift_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_RD_W  = 5;
  // Widest destination tag the queue entry can carry; the top uses the low RD_W bits.
  localparam int RD_W_MAX  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    WB     = 2'd3
  } shift_state_t;

  typedef struct packed {
    logic [31:0]         op1;
    logic [31:0]         op2;
    logic [31:0]         imm;
    logic [1:0]          use_part;
    logic [1:0]          mode1;
    logic [2:0]          mode2;
    logic [RD_W_MAX-1:0] rd;
  } shift_op_t;

endpackage

// File: rtl/shift_op_fifo.sv
// rtl/shift_op_fifo.sv - synchronous FIFO of shift_op_t with flush
module shift_op_fifo
  import rv_shift_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_flush,
  input  logic      i_push,
  input  shift_op_t i_push_op,
  input  logic      i_pop,
  output shift_op_t o_head_op,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Plain wrapping pointers with one slot kept free, so full/empty need no
  // extra bit: the queue holds at most DEPTH-1 ops.
  shift_op_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic            w_push;
  logic            w_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = ((r_wptr + AW'(1)) == r_rptr);
  assign w_push    = i_push & ~o_full & ~i_flush;
  assign w_pop     = i_pop & ~o_empty & ~i_flush;
  assign o_head_op = r_mem[r_rptr];

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_push_op;
    end
  end

  // Pointer update; flush empties the queue and drops a simultaneous push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

endmodule

// File: rtl/shift_issue_ctrl.sv
// rtl/shift_issue_ctrl.sv - issue/sequencing stage for the SHIFT unit (optional SHIFT_TIMEOUT_EN)
module shift_issue_ctrl
  import rv_shift_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int RD_W    = DEF_RD_W,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_op1,
  input  logic [31:0]     in_op2,
  input  logic [31:0]     in_imm,
  input  logic [1:0]      in_use_part,
  input  logic [1:0]      in_mode1,
  input  logic [2:0]      in_mode2,
  input  logic [RD_W-1:0] in_rd,
  output logic            sh_start,
  output logic [31:0]     sh_op1,
  output logic [31:0]     sh_op2,
  output logic [31:0]     sh_imm,
  output logic [1:0]      sh_use_part,
  output logic [1:0]      sh_mode1,
  output logic [2:0]      sh_mode2,
  input  logic            sh_done,
  input  logic [31:0]     sh_res,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            err_timeout
);

  shift_state_t        r_state;
  shift_state_t        w_state_nxt;
  shift_op_t           w_push_op;
  shift_op_t           w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_timeout;
  logic [RD_W_MAX-1:0] w_unused_rd;

  logic [31:0]         r_op1;
  logic [31:0]         r_op2;
  logic [31:0]         r_imm;
  logic [1:0]          r_use_part;
  logic [1:0]          r_mode1;
  logic [2:0]          r_mode2;
  logic [RD_W-1:0]     r_rd;
  logic                r_discard;
  logic [31:0]         r_wb_data;
  logic [RD_W-1:0]     r_wb_rd;

  assign w_push_op.op1      = in_op1;
  assign w_push_op.op2      = in_op2;
  assign w_push_op.imm      = in_imm;
  assign w_push_op.use_part = in_use_part;
  assign w_push_op.mode1    = in_mode1;
  assign w_push_op.mode2    = in_mode2;
  assign w_push_op.rd       = RD_W_MAX'(in_rd);
  assign w_unused_rd        = w_head.rd;

  // Only pop while idle, and never in a flush cycle (the queue is being dropped).
  assign w_pop = (r_state == IDLE) & ~w_empty & ~flush;

  shift_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .i_push    (in_valid),
    .i_push_op (w_push_op),
    .i_pop     (w_pop),
    .o_head_op (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

`ifdef SHIFT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_err;

  // Cycles spent in WAIT for the current op; cleared in every other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (r_state != WAIT) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  assign w_timeout = (r_state == WAIT) & ~sh_done & (r_tcnt == TW'(TIMEOUT - 1));

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err_timeout = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a done pulse outside WAIT is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_pop) w_state_nxt = LAUNCH;
      LAUNCH: w_state_nxt = WAIT;
      WAIT: begin
        if (sh_done) begin
          w_state_nxt = (r_discard | flush) ? IDLE : WB;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end
      end
      WB:     if (flush | wb_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand/control registers: loaded on pop, held until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_imm      <= '0;
      r_use_part <= '0;
      r_mode1    <= '0;
      r_mode2    <= '0;
      r_rd       <= '0;
    end else if (w_pop) begin
      r_op1      <= w_head.op1;
      r_op2      <= w_head.op2;
      r_imm      <= w_head.imm;
      r_use_part <= w_head.use_part;
      r_mode1    <= w_head.mode1;
      r_mode2    <= w_head.mode2;
      r_rd       <= w_head.rd[RD_W-1:0];
    end
  end

  // Discard marker: a flush while the op is in SHIFT drops its result on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_discard <= 1'b0;
    end else if ((r_state == WAIT) && (sh_done || w_timeout)) begin
      r_discard <= 1'b0;
    end else if (flush && ((r_state == LAUNCH) || (r_state == WAIT))) begin
      r_discard <= 1'b1;
    end
  end

  // Writeback registers: capture the result and tag on a kept completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_data <= '0;
      r_wb_rd   <= '0;
    end else if ((r_state == WAIT) && sh_done && !r_discard && !flush) begin
      r_wb_data <= sh_res;
      r_wb_rd   <= r_rd;
    end
  end

  assign in_ready    = ~w_full;
  assign sh_start    = (r_state == LAUNCH);
  assign sh_op1      = r_op1;
  assign sh_op2      = r_op2;
  assign sh_imm      = r_imm;
  assign sh_use_part = r_use_part;
  assign sh_mode1    = r_mode1;
  assign sh_mode2    = r_mode2;
  assign wb_valid    = (r_state == WB);
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;

endmodule
